// File: rtl/up_dn_cmd_pkg.sv
// Shared types and helpers for the up/down counter command front-end.
package up_dn_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DLY,
        HOLD_RPT
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    localparam int RPT_DELAY_DEF = 16;
    localparam int RPT_RATE_DEF  = 4;

    // Wide enough to hold the larger of the two reload values.
    function automatic int tmr_width(input int dly, input int rate);
        int m;
        m = (dly > rate) ? dly : rate;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TMR_W = tmr_width(RPT_DELAY_DEF, RPT_RATE_DEF);

endpackage

// File: rtl/up_dn_cmd_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter for one push-button.
// Emits the debounced level and a one-cycle strobe on each accepted press.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                // This sample is the DB_CYCLES-th consecutive disagreement.
                level <= sync[1];
                rise  <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Button front-end for the 5-bit up/down counter: debounce, press pulses,
// load capture and hold-to-repeat with High/Low limit inhibit.
module up_dn_cmd_ctrl
    import up_dn_cmd_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 4,
    parameter int RPT_DELAY = RPT_DELAY_DEF,
    parameter int RPT_RATE  = RPT_RATE_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Up_Btn,
    input  logic             Dn_Btn,
    input  logic             Ld_Btn,
    input  logic [WIDTH-1:0] Sw,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [WIDTH-1:0] IN
);

    localparam int TW = tmr_width(RPT_DELAY, RPT_RATE);
    localparam logic [TW-1:0] DLY_LD  = TW'(RPT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LD = TW'(RPT_RATE - 1);

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic ld_lvl_unused, ld_rise;

    logic [WIDTH-1:0] sw_meta, sw_sync;

    state_t        state, state_n;
    dir_t          dir, dir_n;
    logic [TW-1:0] tmr, tmr_n;

    logic             up_n, dn_n, ld_n;
    logic [WIDTH-1:0] in_n;
    logic             held, inhibit, expired, rpt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
        .clk   (CLK),
        .rst   (RST),
        .raw   (Up_Btn),
        .level (up_lvl),
        .rise  (up_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn (
        .clk   (CLK),
        .rst   (RST),
        .raw   (Dn_Btn),
        .level (dn_lvl),
        .rise  (dn_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_ld (
        .clk   (CLK),
        .rst   (RST),
        .raw   (Ld_Btn),
        .level (ld_lvl_unused),
        .rise  (ld_rise)
    );

    always_comb begin
        state_n = state;
        dir_n   = dir;
        tmr_n   = tmr;
        up_n    = 1'b0;
        dn_n    = 1'b0;
        ld_n    = 1'b0;
        in_n    = IN;
        rpt     = 1'b0;
        held    = (dir == DIR_UP) ? up_lvl : dn_lvl;
        inhibit = (dir == DIR_UP) ? High : Low;
        expired = (tmr == '0);

        // Same priority as the counter: a losing press is simply dropped.
        priority case (1'b1)
            ld_rise: begin
                ld_n    = 1'b1;
                in_n    = sw_sync;
                state_n = IDLE;
                tmr_n   = '0;
            end
            dn_rise: begin
                dn_n    = 1'b1;
                dir_n   = DIR_DN;
                tmr_n   = DLY_LD;
                state_n = HOLD_DLY;
            end
            up_rise: begin
                up_n    = 1'b1;
                dir_n   = DIR_UP;
                tmr_n   = DLY_LD;
                state_n = HOLD_DLY;
            end
            default: begin
                case (state)
                    IDLE: ;
                    HOLD_DLY, HOLD_RPT: begin
                        if (!held) begin
                            state_n = IDLE;
                            tmr_n   = '0;
                        end else if (expired) begin
                            // Inhibited expiries keep the cadence but stay put.
                            tmr_n = RATE_LD;
                            if (!inhibit) begin
                                rpt     = 1'b1;
                                state_n = HOLD_RPT;
                            end
                        end else begin
                            tmr_n = tmr - TW'(1);
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        endcase

        if (rpt) begin
            up_n = (dir == DIR_UP);
            dn_n = (dir == DIR_DN);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta <= '0;
            sw_sync <= '0;
            state   <= IDLE;
            dir     <= DIR_UP;
            tmr     <= '0;
            Up      <= 1'b0;
            Down    <= 1'b0;
            Load    <= 1'b0;
            IN      <= '0;
        end else begin
            sw_meta <= Sw;
            sw_sync <= sw_meta;
            state   <= state_n;
            dir     <= dir_n;
            tmr     <= tmr_n;
            Up      <= up_n;
            Down    <= dn_n;
            Load    <= ld_n;
            IN      <= in_n;
        end
    end

endmodule
